// File: rtl/kgp_pkg.sv
// rtl/kgp_pkg.sv - shared KGP-RISC PC-select encodings and sequencer state codes
package kgp_pkg;

    typedef logic [1:0] pcsel_t;

    localparam pcsel_t PCSEL_SEQ = 2'b00;
    localparam pcsel_t PCSEL_REL = 2'b01;
    localparam pcsel_t PCSEL_ABS = 2'b10;
    localparam pcsel_t PCSEL_RET = 2'b11;

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - control-in / PC-out bundle between ID/EX, branch select and the sequencer
interface pc_sequencer_if #(
    parameter int PC_W  = 16,
    parameter int OFF_W = 10
);
    logic [1:0]       PCSel;
    logic [OFF_W-1:0] Offset;
    logic [PC_W-1:0]  Target;
    logic             Call;
    logic             Stall;
    logic [PC_W-1:0]  PC;
    logic             PCValid;
    logic             StackFull;
    logic             StackEmpty;
    logic             Fault;

    modport master (
        output PCSel, Offset, Target, Call, Stall,
        input  PC, PCValid, StackFull, StackEmpty, Fault
    );

    modport slave (
        input  PCSel, Offset, Target, Call, Stall,
        output PC, PCValid, StackFull, StackEmpty, Fault
    );
endinterface

// File: rtl/ret_stack.sv
// rtl/ret_stack.sv - LIFO return-address stack; reset clears the pointer only
module ret_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int SPW  = AW + 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           push,
    input  logic           pop,
    input  logic [W-1:0]   wdata,
    output logic [W-1:0]   rdata,
    output logic [SPW-1:0] sp,
    output logic           full,
    output logic           empty
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] top_idx;

    // At sp==DEPTH the low bits wrap to 0, so top_idx still lands on DEPTH-1.
    assign wr_idx  = sp[AW-1:0];
    assign top_idx = sp[AW-1:0] - AW'(1);
    assign rdata   = mem[top_idx];
    assign full    = (sp == SPW'(DEPTH));
    assign empty   = (sp == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SPW'(1);
        end else if (pop && !empty) begin
            sp <= sp - SPW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= wdata;
        end
    end
endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - KGP-RISC program counter: next-PC mux, adder, boot/run/fault FSM
module pc_sequencer
    import kgp_pkg::*;
#(
    parameter int              PC_W        = 16,
    parameter int              OFF_W       = 10,
    parameter int              STACK_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    localparam int             SPW         = $clog2(STACK_DEPTH) + 1
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  bus
);
    logic [1:0]      state;
    logic [PC_W-1:0] pc;
    logic            fault;
    logic [PC_W-1:0] pc_plus1;
    logic [PC_W-1:0] off_ext;
    logic [PC_W-1:0] next_pc;
    logic [PC_W-1:0] ret_addr;
    logic [SPW-1:0]  sp;
    logic            stk_full;
    logic            stk_empty;
    logic            want_push;
    logic            want_pop;
    logic            step;
    logic            overflow;
    logic            underflow;

    assign pc_plus1 = pc + PC_W'(1);
    assign off_ext  = {{(PC_W-OFF_W){bus.Offset[OFF_W-1]}}, bus.Offset};

    // Call only means something on a redirect; PCSel=RET can never push.
    assign want_push = bus.Call && (bus.PCSel == PCSEL_REL || bus.PCSel == PCSEL_ABS);
    assign want_pop  = (bus.PCSel == PCSEL_RET);
    assign step      = (state == ST_RUN) && !bus.Stall;
    assign overflow  = want_push && stk_full;
    assign underflow = want_pop && stk_empty;

    always_comb begin
        next_pc = pc_plus1;
        case (bus.PCSel)
            PCSEL_SEQ: next_pc = pc_plus1;
            PCSEL_REL: next_pc = pc_plus1 + off_ext;
            PCSEL_ABS: next_pc = bus.Target;
            PCSEL_RET: next_pc = ret_addr;
            default:   next_pc = pc_plus1;
        endcase
    end

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (PC_W)
    ) u_ret_stack (
        .clk   (clk),
        .reset (reset),
        .push  (step && want_push && !stk_full),
        .pop   (step && want_pop && !stk_empty),
        .wdata (pc_plus1),
        .rdata (ret_addr),
        .sp    (sp),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= RESET_PC;
            state <= ST_BOOT;
            fault <= 1'b0;
        end else begin
            case (state)
                ST_BOOT: state <= ST_RUN;
                ST_RUN: begin
                    if (!bus.Stall) begin
                        if (overflow || underflow) begin
                            fault <= 1'b1;
                            state <= ST_FAULT;
                        end else begin
                            pc <= next_pc;
                        end
                    end
                end
                ST_FAULT: state <= ST_FAULT;
                default:  state <= ST_BOOT;
            endcase
        end
    end

    assign bus.PC         = pc;
    assign bus.PCValid    = (state == ST_RUN);
    assign bus.StackFull  = (sp == SPW'(STACK_DEPTH));
    assign bus.StackEmpty = (sp == '0);
    assign bus.Fault      = fault;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed vector bench for pc_sequencer
module tb_pc_sequencer;
    import kgp_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    pc_sequencer_if #(.PC_W(16), .OFF_W(10)) bus ();

    pc_sequencer #(
        .PC_W        (16),
        .OFF_W       (10),
        .STACK_DEPTH (4),
        .RESET_PC    (16'h0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic        call;
        logic [1:0]  sel;
        logic [9:0]  off;
        logic [15:0] tgt;
        logic [15:0] pc;
        logic        valid;
        logic        full;
        logic        empty;
        logic        fault;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(logic rst, logic stall, logic call, logic [1:0] sel,
                                 logic [9:0] off, logic [15:0] tgt, logic [15:0] pc,
                                 logic valid, logic full, logic empty, logic fault);
        vec_t v;
        v.rst = rst; v.stall = stall; v.call = call; v.sel = sel; v.off = off; v.tgt = tgt;
        v.pc = pc; v.valid = valid; v.full = full; v.empty = empty; v.fault = fault;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(vec_t v);
        reset      = v.rst;
        bus.Stall  = v.stall;
        bus.Call   = v.call;
        bus.PCSel  = v.sel;
        bus.Offset = v.off;
        bus.Target = v.tgt;
    endtask

    task automatic apply(vec_t v, int idx);
        drive(v);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d.PC", idx),         32'(bus.PC),         32'(v.pc));
        chk($sformatf("v%0d.PCValid", idx),    32'(bus.PCValid),    32'(v.valid));
        chk($sformatf("v%0d.StackFull", idx),  32'(bus.StackFull),  32'(v.full));
        chk($sformatf("v%0d.StackEmpty", idx), 32'(bus.StackEmpty), 32'(v.empty));
        chk($sformatf("v%0d.Fault", idx),      32'(bus.Fault),      32'(v.fault));
    endtask

    initial begin
        reset = 1'b1;
        bus.Stall = 1'b0; bus.Call = 1'b0; bus.PCSel = PCSEL_SEQ;
        bus.Offset = '0; bus.Target = '0;

        //             rst stl cal sel        off     tgt       pc       vld ful emp flt
        vecs.push_back(mkv(1, 0, 0, PCSEL_SEQ, 10'h000, 16'h0000, 16'h0000, 0, 0, 1, 0));
        vecs.push_back(mkv(0, 0, 0, PCSEL_SEQ, 10'h000, 16'h0000, 16'h0000, 1, 0, 1, 0));
        vecs.push_back(mkv(0, 0, 0, PCSEL_SEQ, 10'h000, 16'h0000, 16'h0001, 1, 0, 1, 0));
        vecs.push_back(mkv(0, 0, 0, PCSEL_SEQ, 10'h000, 16'h0000, 16'h0002, 1, 0, 1, 0));
        vecs.push_back(mkv(0, 0, 0, PCSEL_SEQ, 10'h000, 16'h0000, 16'h0003, 1, 0, 1, 0));
        vecs.push_back(mkv(0, 0, 0, PCSEL_ABS, 10'h000, 16'h0010, 16'h0010, 1, 0, 1, 0));
        vecs.push_back(mkv(0, 0, 0, PCSEL_REL, 10'h3FC, 16'h0000, 16'h000D, 1, 0, 1, 0));
        vecs.push_back(mkv(0, 0, 0, PCSEL_REL, 10'h005, 16'h0000, 16'h0013, 1, 0, 1, 0));
        vecs.push_back(mkv(0, 0, 0, PCSEL_ABS, 10'h000, 16'h0020, 16'h0020, 1, 0, 1, 0));
        vecs.push_back(mkv(0, 0, 1, PCSEL_ABS, 10'h000, 16'h0100, 16'h0100, 1, 0, 0, 0));
        vecs.push_back(mkv(0, 0, 0, PCSEL_RET, 10'h000, 16'h0000, 16'h0021, 1, 0, 1, 0));
        vecs.push_back(mkv(0, 0, 1, PCSEL_SEQ, 10'h000, 16'h0000, 16'h0022, 1, 0, 1, 0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mkv(0, 1, 1, PCSEL_ABS, 10'h000, 16'h0500, 16'h0022, 1, 0, 1, 0));
        vecs.push_back(mkv(0, 0, 0, PCSEL_ABS, 10'h000, 16'hFFFF, 16'hFFFF, 1, 0, 1, 0));
        vecs.push_back(mkv(0, 0, 0, PCSEL_SEQ, 10'h000, 16'h0000, 16'h0000, 1, 0, 1, 0));
        vecs.push_back(mkv(0, 0, 0, PCSEL_REL, 10'h3FE, 16'h0000, 16'hFFFF, 1, 0, 1, 0));
        vecs.push_back(mkv(0, 0, 0, PCSEL_REL, 10'h001, 16'h0000, 16'h0001, 1, 0, 1, 0));
        // Fill the stack: pushes 0x0002, 0x0101, 0x0201, 0x0301
        vecs.push_back(mkv(0, 0, 1, PCSEL_ABS, 10'h000, 16'h0100, 16'h0100, 1, 0, 0, 0));
        vecs.push_back(mkv(0, 0, 1, PCSEL_ABS, 10'h000, 16'h0200, 16'h0200, 1, 0, 0, 0));
        vecs.push_back(mkv(0, 0, 1, PCSEL_ABS, 10'h000, 16'h0300, 16'h0300, 1, 0, 0, 0));
        vecs.push_back(mkv(0, 0, 1, PCSEL_ABS, 10'h000, 16'h0400, 16'h0400, 1, 1, 0, 0));
        vecs.push_back(mkv(0, 0, 0, PCSEL_RET, 10'h000, 16'h0000, 16'h0301, 1, 0, 0, 0));
        vecs.push_back(mkv(0, 0, 1, PCSEL_ABS, 10'h000, 16'h0400, 16'h0400, 1, 1, 0, 0));
        vecs.push_back(mkv(0, 0, 1, PCSEL_ABS, 10'h000, 16'h0500, 16'h0400, 0, 1, 0, 1));
        vecs.push_back(mkv(0, 0, 0, PCSEL_SEQ, 10'h000, 16'h0000, 16'h0400, 0, 1, 0, 1));
        vecs.push_back(mkv(0, 0, 0, PCSEL_RET, 10'h000, 16'h0000, 16'h0400, 0, 1, 0, 1));
        vecs.push_back(mkv(1, 0, 0, PCSEL_SEQ, 10'h000, 16'h0000, 16'h0000, 0, 0, 1, 0));
        vecs.push_back(mkv(0, 0, 0, PCSEL_SEQ, 10'h000, 16'h0000, 16'h0000, 1, 0, 1, 0));
        vecs.push_back(mkv(0, 0, 0, PCSEL_RET, 10'h000, 16'h0000, 16'h0000, 0, 0, 1, 1));
        vecs.push_back(mkv(0, 0, 0, PCSEL_SEQ, 10'h000, 16'h0000, 16'h0000, 0, 0, 1, 1));
        vecs.push_back(mkv(1, 1, 1, PCSEL_ABS, 10'h000, 16'h0123, 16'h0000, 0, 0, 1, 0));
        vecs.push_back(mkv(0, 0, 0, PCSEL_SEQ, 10'h000, 16'h0000, 16'h0000, 1, 0, 1, 0));

        foreach (vecs[i]) apply(vecs[i], i);

        // PC must not follow inputs combinationally.
        drive(mkv(0, 0, 0, PCSEL_ABS, 10'h000, 16'h0777, 16'h0, 0, 0, 0, 0));
        #2;
        chk("no_comb_path.PC", 32'(bus.PC), 32'h0000);
        apply(mkv(0, 0, 0, PCSEL_ABS, 10'h000, 16'h0777, 16'h0777, 1, 0, 1, 0), 100);

        // Nested call/return restores addresses in LIFO order.
        apply(mkv(0, 0, 1, PCSEL_ABS, 10'h000, 16'h0100, 16'h0100, 1, 0, 0, 0), 101);
        apply(mkv(0, 0, 1, PCSEL_REL, 10'h3F0, 16'h0000, 16'h00F1, 1, 0, 0, 0), 102);
        apply(mkv(0, 0, 0, PCSEL_RET, 10'h000, 16'h0000, 16'h0101, 1, 0, 0, 0), 103);
        apply(mkv(0, 0, 0, PCSEL_RET, 10'h000, 16'h0000, 16'h0778, 1, 0, 1, 0), 104);

        // Underflow, then Fault must stay set and PC frozen whatever the inputs do.
        apply(mkv(0, 0, 0, PCSEL_RET, 10'h000, 16'h0000, 16'h0778, 0, 0, 1, 1), 105);
        for (int k = 0; k < 4; k++)
            apply(mkv(0, k[0], 1, 2'(k), 10'h011, 16'h0999, 16'h0778, 0, 0, 1, 1), 106 + k);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
